// File: rtl/pru_draw_engine_if.sv
// Command and framebuffer-write bundle for pru_draw_engine.
// master = command/framebuffer side, slave = engine side.
interface pru_draw_engine_if #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int PIX_BITS = 2
);
    localparam int X_W    = $clog2(H_RES);
    localparam int Y_W    = $clog2(V_RES);
    localparam int ADDR_W = $clog2(H_RES * V_RES);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [X_W-1:0]      cmd_x;
    logic [Y_W-1:0]      cmd_y;
    logic [X_W-1:0]      cmd_w;
    logic [Y_W-1:0]      cmd_h;
    logic [PIX_BITS-1:0] cmd_color;
    logic                abort;
    logic                fb_we;
    logic                fb_ready;
    logic [ADDR_W-1:0]   fb_addr;
    logic [PIX_BITS-1:0] fb_data;
    logic                busy;
    logic                done;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, abort, fb_ready,
        input  cmd_ready, fb_we, fb_addr, fb_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, abort, fb_ready,
        output cmd_ready, fb_we, fb_addr, fb_data, busy, done
    );
endinterface

// File: rtl/pru_draw_engine.sv
// Rasterises RECT / filled CIRCLE / CLEAR (CLEAR only with PRU_CLEAR_EN) into a framebuffer write port, clipped.
// Latency: accept at edge k, first registered fb_we after edge k+1; one scan position per clock.
// Backpressure: fb_we with !fb_ready holds addr/data and stalls the scan; cmd_ready only in IDLE.
module pru_draw_engine #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int PIX_BITS = 2
) (
    input logic              clk,
    input logic              rst_n,
    pru_draw_engine_if.slave bus
);
    localparam int X_W    = $clog2(H_RES);
    localparam int Y_W    = $clog2(V_RES);
    localparam int ADDR_W = $clog2(H_RES * V_RES);
    localparam int CW     = ((X_W > Y_W) ? X_W : Y_W) + 2;
    localparam int SW     = 2 * CW;

    localparam logic signed [CW-1:0] H_LIM = CW'(H_RES);
    localparam logic signed [CW-1:0] V_LIM = CW'(V_RES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECT,
        S_CIRC,
`ifdef PRU_CLEAR_EN
        S_CLEAR,
`endif
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [CW-1:0] cur_x, cur_y, x_lo, x_hi, y_hi, cx, cy;
    logic signed [SW-1:0] r2;
    logic                 scan_end;
    logic [PIX_BITS-1:0]  color;

    logic signed [CW-1:0] c_x, c_y, c_w, c_h;
    logic signed [CW-1:0] ini_x, ini_y, ini_xhi, ini_yhi;
    logic signed [SW-1:0] rr;
    logic signed [CW-1:0] dx, dy;
    logic signed [SW-1:0] dx_w, dy_w, sq_sum;
    logic                 accept, scanning, adv, in_screen, hit, last_x, last_y;
    logic [ADDR_W-1:0]    pix_addr;

    assign c_x = {{(CW-X_W){1'b0}}, bus.cmd_x};
    assign c_y = {{(CW-Y_W){1'b0}}, bus.cmd_y};
    assign c_w = {{(CW-X_W){1'b0}}, bus.cmd_w};
    assign c_h = {{(CW-Y_W){1'b0}}, bus.cmd_h};
    assign rr  = {{(SW-Y_W){1'b0}}, bus.cmd_h};

    assign accept = bus.cmd_valid && (state == S_IDLE) && !bus.abort;
    assign adv    = !bus.fb_we || bus.fb_ready;

    always_comb begin
        scanning = (state == S_RECT) || (state == S_CIRC);
`ifdef PRU_CLEAR_EN
        scanning = scanning || (state == S_CLEAR);
`endif
    end

    // Scan window start and inclusive end, widened so sums never wrap.
    always_comb begin
        ini_x   = c_x;
        ini_y   = c_y;
        ini_xhi = c_x + c_w - CW'(1);
        ini_yhi = c_y + c_h - CW'(1);
        case (bus.cmd_op)
            2'b01: begin
                ini_x   = c_x - c_h;
                ini_y   = c_y - c_h;
                ini_xhi = c_x + c_h;
                ini_yhi = c_y + c_h;
            end
`ifdef PRU_CLEAR_EN
            2'b10: begin
                ini_x   = '0;
                ini_y   = '0;
                ini_xhi = CW'(H_RES - 1);
                ini_yhi = CW'(V_RES - 1);
            end
`endif
            default: ;
        endcase
    end

    assign dx     = cur_x - cx;
    assign dy     = cur_y - cy;
    assign dx_w   = {{(SW-CW){dx[CW-1]}}, dx};
    assign dy_w   = {{(SW-CW){dy[CW-1]}}, dy};
    assign sq_sum = dx_w * dx_w + dy_w * dy_w;

    assign in_screen = !cur_x[CW-1] && (cur_x < H_LIM) && !cur_y[CW-1] && (cur_y < V_LIM);
    assign hit       = in_screen && ((state != S_CIRC) || (sq_sum <= r2));
    assign last_x    = (cur_x == x_hi);
    assign last_y    = (cur_y == y_hi);
    assign pix_addr  = ADDR_W'(cur_y) * ADDR_W'(H_RES) + ADDR_W'(cur_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        2'b00:   state_nxt = (bus.cmd_w == '0 || bus.cmd_h == '0) ? S_DONE : S_RECT;
                        2'b01:   state_nxt = S_CIRC;
`ifdef PRU_CLEAR_EN
                        2'b10:   state_nxt = S_CLEAR;
`endif
                        default: state_nxt = S_DONE;
                    endcase
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: begin
                if (bus.abort)            state_nxt = S_IDLE;
                else if (adv && scan_end) state_nxt = S_DONE;
            end
        endcase
    end

    // scan_end marks that the last position has been issued; DONE waits for its write to drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x       <= '0;
            cur_y       <= '0;
            x_lo        <= '0;
            x_hi        <= '0;
            y_hi        <= '0;
            cx          <= '0;
            cy          <= '0;
            r2          <= '0;
            color       <= '0;
            scan_end    <= 1'b0;
            bus.fb_we   <= 1'b0;
            bus.fb_addr <= '0;
            bus.fb_data <= '0;
        end else if (accept) begin
            cur_x     <= ini_x;
            cur_y     <= ini_y;
            x_lo      <= ini_x;
            x_hi      <= ini_xhi;
            y_hi      <= ini_yhi;
            cx        <= c_x;
            cy        <= c_y;
            r2        <= rr * rr;
            color     <= bus.cmd_color;
            scan_end  <= 1'b0;
            bus.fb_we <= 1'b0;
        end else if (scanning && !bus.abort) begin
            if (adv) begin
                if (scan_end) begin
                    bus.fb_we <= 1'b0;
                end else begin
                    bus.fb_we <= hit;
                    if (hit) begin
                        bus.fb_addr <= pix_addr;
                        bus.fb_data <= color;
                    end
                    if (last_x) begin
                        cur_x <= x_lo;
                        cur_y <= cur_y + CW'(1);
                    end else begin
                        cur_x <= cur_x + CW'(1);
                    end
                    scan_end <= last_x && last_y;
                end
            end
        end else begin
            bus.fb_we <= 1'b0;
        end
    end

    assign bus.cmd_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
endmodule

// File: tb/tb_pru_draw_engine.sv
// Directed bench for pru_draw_engine on a 16x12, 2-bit screen; honours PRU_CLEAR_EN for the CLEAR vector.
module tb_pru_draw_engine;
    localparam int H  = 16;
    localparam int V  = 12;
    localparam int PB = 2;
    localparam int NV = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pru_draw_engine_if #(.H_RES(H), .V_RES(V), .PIX_BITS(PB)) bus ();
    pru_draw_engine #(.H_RES(H), .V_RES(V), .PIX_BITS(PB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] op;
        int x, y, w, h, color, n, base, stall;
    } vec_t;

    vec_t vecs[NV];
    int   exp_flat[32];
    int   tests = 0;
    int   fails = 0;
    int   got_addr[$];
    int   got_data[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input int x, input int y, input int w, input int h, input int c);
        @(negedge clk);
        bus.cmd_op    = op;
        bus.cmd_x     = x[3:0];
        bus.cmd_y     = y[3:0];
        bus.cmd_w     = w[3:0];
        bus.cmd_h     = h[3:0];
        bus.cmd_color = c[1:0];
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int c, wecyc, ndone, lat, first, stalls, hold_a, e;
        c = 0; wecyc = 0; ndone = 0; lat = -1; first = -1; stalls = 0; hold_a = 0;
        got_addr.delete();
        got_data.delete();
        bus.fb_ready = (v.stall == 0);
        issue(v.op, v.x, v.y, v.w, v.h, v.color);
        while (ndone == 0 && c < 1000) begin
            @(negedge clk);
            c++;
            if (bus.fb_we && !bus.fb_ready) begin
                if (stalls == 0) hold_a = int'(bus.fb_addr);
                else check({nm, " hold_addr"}, int'(bus.fb_addr), hold_a);
                if (stalls >= v.stall) bus.fb_ready = 1'b1;
                else stalls++;
            end
            if (bus.fb_we) begin
                wecyc++;
                if (first < 0) first = c;
            end
            if (bus.fb_we && bus.fb_ready) begin
                got_addr.push_back(int'(bus.fb_addr));
                got_data.push_back(int'(bus.fb_data));
            end
            if (bus.done) begin
                ndone++;
                lat = c;
            end
        end
        check({nm, " done_seen"}, ndone, 1);
        @(negedge clk);
        check({nm, " busy_after"}, int'(bus.busy), 0);
        check({nm, " done_once"}, int'(bus.done), 0);
        check({nm, " ready_after"}, int'(bus.cmd_ready), 1);
        bus.fb_ready = 1'b1;
        check({nm, " writes"}, got_addr.size(), v.n);
        check({nm, " we_cycles"}, wecyc, v.n + v.stall);
        for (int i = 0; i < v.n && i < got_addr.size(); i++) begin
            e = (v.base < 0) ? i : exp_flat[v.base + i];
            check($sformatf("%s addr[%0d]", nm, i), got_addr[i], e);
            check($sformatf("%s data[%0d]", nm, i), got_data[i], v.color);
        end
        if (v.n == 0) check({nm, " done_latency"}, lat, 1);
        if (v.op == 2'b00 && v.n > 0) check({nm, " first_we"}, first, 2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;
        bus.abort     = 1'b0;
        bus.fb_ready  = 1'b1;

        exp_flat = '{84, 85, 86, 100, 101, 102,
                     18, 33, 34, 35, 50,
                     0, 1, 16,
                     190, 191,
                     191,
                     53, 68, 69, 70, 83, 84, 85, 86, 87, 100, 101, 102, 117,
                     0, 1};
        //           op     x   y   w  h  col  n   base stall
        vecs[0]  = '{2'd0,  4,  5,  3, 2, 2,   6,  0,   0};
        vecs[1]  = '{2'd1,  2,  2,  0, 1, 1,   5,  6,   0};
        vecs[2]  = '{2'd1,  0,  0,  0, 1, 3,   3,  11,  0};
        vecs[3]  = '{2'd0,  14, 11, 4, 3, 1,   2,  14,  0};
        vecs[4]  = '{2'd0,  3,  3,  0, 2, 2,   0,  0,   0};
        vecs[5]  = '{2'd0,  3,  3,  2, 0, 2,   0,  0,   0};
        vecs[6]  = '{2'd3,  1,  1,  1, 1, 1,   0,  0,   0};
        vecs[7]  = '{2'd1,  15, 11, 0, 0, 2,   1,  16,  0};
        vecs[8]  = '{2'd1,  5,  5,  0, 2, 1,   13, 17,  0};
        vecs[9]  = '{2'd0,  0,  0,  2, 1, 3,   2,  30,  3};
`ifdef PRU_CLEAR_EN
        vecs[10] = '{2'd2,  0,  0,  0, 0, 3,   192, -1, 0};
`else
        vecs[10] = '{2'd2,  0,  0,  0, 0, 3,   0,  0,   0};
`endif

        // Reset values
        repeat (2) @(negedge clk);
        check("rst cmd_ready", int'(bus.cmd_ready), 1);
        check("rst fb_we", int'(bus.fb_we), 0);
        check("rst fb_addr", int'(bus.fb_addr), 0);
        check("rst fb_data", int'(bus.fb_data), 0);
        check("rst busy", int'(bus.busy), 0);
        check("rst done", int'(bus.done), 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Abort two cycles into a 4x4 rectangle, then abort+valid while idle
        bus.fb_ready = 1'b1;
        issue(2'd0, 0, 0, 4, 4, 1);
        @(negedge clk);
        @(negedge clk);
        check("abort pre_we", int'(bus.fb_we), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        check("abort fb_we", int'(bus.fb_we), 0);
        check("abort busy", int'(bus.busy), 0);
        check("abort ready", int'(bus.cmd_ready), 1);
        check("abort done", int'(bus.done), 0);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        check("abort idle_busy", int'(bus.busy), 0);
        check("abort idle_done", int'(bus.done), 0);
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;
        run_vec(vecs[0], "after_abort");

        // Asynchronous reset in the middle of a command
        issue(2'd0, 0, 0, 4, 4, 2);
        @(negedge clk);
        @(negedge clk);
        check("mid_rst pre_we", int'(bus.fb_we), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst fb_we", int'(bus.fb_we), 0);
        check("mid_rst busy", int'(bus.busy), 0);
        check("mid_rst fb_addr", int'(bus.fb_addr), 0);
        check("mid_rst ready", int'(bus.cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[1], "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
